count_display: RTL and testbench

Sequential binary-to-decimal display driver for the 8-bit event counter on the DE10-Lite board. It sits downstream of the counter and reads it. On a load strobe it captures an 8-bit binary value and converts it to three BCD digits with an iterative shift-add-3 (double-dabble) engine. It then drives the result onto HEX2..HEX0 as active-low seven-segment patterns, with optional leading-zero blanking.

---
 rtl/count_display_if.sv | 28 ++
 rtl/count_display.sv | 148 ++++++++++++++
 tb/tb_count_display.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/count_display_if.sv
// count_display_if
//   Bundles the data/handshake signals of the count_display driver.
//   master : upstream side, drives value/load, observes status and segments
//   slave  : count_display itself
//   value  - 8-bit unsigned value to display
//   load   - capture strobe
//   busy   - conversion in progress
//   done   - one-cycle pulse when HEX0..HEX2 carry a new result
//   HEX0..HEX2 - active-low seven-segment patterns {dp,g,f,e,d,c,b,a}
interface count_display_if;
  logic [7:0] value;
  logic       load;
  logic       busy;
  logic       done;
  logic [7:0] HEX0;
  logic [7:0] HEX1;
  logic [7:0] HEX2;

  modport master (
    output value, load,
    input  busy, done, HEX0, HEX1, HEX2
  );

  modport slave (
    input  value, load,
    output busy, done, HEX0, HEX1, HEX2
  );
endinterface

// File: rtl/count_display.sv
// count_display
//   Captures an 8-bit binary value on load, converts it to three BCD digits
//   with an iterative shift-add-3 engine (one step per clock), then latches
//   active-low seven-segment patterns onto HEX2..HEX0.
//   ADC_CLK_10 - 10 MHz clock, all registers update on its rising edge
//   rst        - synchronous active-high reset
//   bus        - count_display_if.slave (value, load, busy, done, HEX0..HEX2)
//   BLANK_LZ   - 1 blanks leading zero digits, 0 always shows three digits
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for load; HEX outputs hold the last result
// SHIFT | eight double-dabble steps, one per clock
// LATCH | encode BCD nibbles onto HEX2..HEX0, pulse done
module count_display #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic            ADC_CLK_10,
  input  logic            rst,
  count_display_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] bcd_q,   bcd_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic [7:0]  hex0_q,  hex0_d;
  logic [7:0]  hex1_q,  hex1_d;
  logic [7:0]  hex2_q,  hex2_d;

  logic [11:0] bcd_adj;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Values 10..15 cannot come out of the converter; show them as blank.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  always_comb begin
    bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hex0_d  = hex0_q;
    hex1_d  = hex1_q;
    hex2_d  = hex2_q;

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          shift_d = bus.value;
          bcd_d   = 12'd0;
          cnt_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // Adjust first, then shift {bcd, shift} left as one 20-bit word.
        bcd_d   = {bcd_adj[10:0], shift_q[7]};
        shift_d = {shift_q[6:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = LATCH;
        end
      end

      LATCH: begin
        hex0_d = seg7(bcd_q[3:0]);
        hex1_d = (BLANK_LZ && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0))
                 ? 8'hFF : seg7(bcd_q[7:4]);
        hex2_d = (BLANK_LZ && (bcd_q[11:8] == 4'd0))
                 ? 8'hFF : seg7(bcd_q[11:8]);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= 8'd0;
      bcd_q   <= 12'd0;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hex0_q  <= 8'hFF;
      hex1_q  <= 8'hFF;
      hex2_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.HEX0 = hex0_q;
  assign bus.HEX1 = hex1_q;
  assign bus.HEX2 = hex2_q;

endmodule

// File: tb/tb_count_display.sv
// Bench for count_display: two instances (leading-zero blanking on and off)
// share one stimulus stream and are compared every cycle against a
// cycle-counting model that derives the digits with integer division.
module tb_count_display;

  logic       clk;
  logic       rst;
  logic [7:0] value_r;
  logic       load_r;
  bit         cmp_en;

  int n_total;
  int n_pass;
  int n_fail;

  count_display_if bus_b ();
  count_display_if bus_n ();

  assign bus_b.value = value_r;
  assign bus_b.load  = load_r;
  assign bus_n.value = value_r;
  assign bus_n.load  = load_r;

  count_display #(.BLANK_LZ(1'b1)) dut_b (
    .ADC_CLK_10 (clk),
    .rst        (rst),
    .bus        (bus_b.slave)
  );

  count_display #(.BLANK_LZ(1'b0)) dut_n (
    .ADC_CLK_10 (clk),
    .rst        (rst),
    .bus        (bus_n.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] seg_tab [0:9];
  initial begin
    seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4;
    seg_tab[3] = 8'hB0; seg_tab[4] = 8'h99; seg_tab[5] = 8'h92;
    seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8; seg_tab[8] = 8'h80;
    seg_tab[9] = 8'h90;
  end

  function automatic logic [7:0] exp_digit(input int v, input bit blank, input int pos);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (pos)
      2:       return (blank && h == 0) ? 8'hFF : seg_tab[h];
      1:       return (blank && h == 0 && t == 0) ? 8'hFF : seg_tab[t];
      default: return seg_tab[o];
    endcase
  endfunction

  // phase 0 = idle; 1..9 = cycles after the accepting edge; result on the 9th.
  int         phase;
  logic [7:0] cap;
  logic       m_done;
  logic [7:0] eb [0:2];
  logic [7:0] en [0:2];
  logic       m_busy;
  assign m_busy = (phase != 0);

  always @(posedge clk) begin
    if (rst) begin
      phase  <= 0;
      m_done <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        eb[k] <= 8'hFF;
        en[k] <= 8'hFF;
      end
    end else if (phase == 0) begin
      m_done <= 1'b0;
      if (load_r) begin
        cap   <= value_r;
        phase <= 1;
      end
    end else if (phase == 9) begin
      phase  <= 0;
      m_done <= 1'b1;
      for (int k = 0; k < 3; k++) begin
        eb[k] <= exp_digit(int'(cap), 1'b1, k);
        en[k] <= exp_digit(int'(cap), 1'b0, k);
      end
    end else begin
      phase  <= phase + 1;
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy_b", {31'd0, bus_b.busy}, {31'd0, m_busy});
      chk("done_b", {31'd0, bus_b.done}, {31'd0, m_done});
      chk("hex0_b", {24'd0, bus_b.HEX0}, {24'd0, eb[0]});
      chk("hex1_b", {24'd0, bus_b.HEX1}, {24'd0, eb[1]});
      chk("hex2_b", {24'd0, bus_b.HEX2}, {24'd0, eb[2]});
      chk("busy_n", {31'd0, bus_n.busy}, {31'd0, m_busy});
      chk("done_n", {31'd0, bus_n.done}, {31'd0, m_done});
      chk("hex0_n", {24'd0, bus_n.HEX0}, {24'd0, en[0]});
      chk("hex1_n", {24'd0, bus_n.HEX1}, {24'd0, en[1]});
      chk("hex2_n", {24'd0, bus_n.HEX2}, {24'd0, en[2]});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_load(input logic [7:0] v, output int lat, output int busy_cnt);
    value_r = v;
    load_r  = 1'b1;
    @(negedge clk);
    load_r   = 1'b0;
    lat      = 0;
    busy_cnt = int'(bus_b.busy);
    while (!bus_b.done && lat < 30) begin
      @(negedge clk);
      lat++;
      busy_cnt += int'(bus_b.busy);
    end
  endtask

  task automatic chk_hex(input string tag, input logic [7:0] h2, input logic [7:0] h1,
                         input logic [7:0] h0, input bit use_n);
    if (use_n) begin
      chk({tag, "_n_hex2"}, {24'd0, bus_n.HEX2}, {24'd0, h2});
      chk({tag, "_n_hex1"}, {24'd0, bus_n.HEX1}, {24'd0, h1});
      chk({tag, "_n_hex0"}, {24'd0, bus_n.HEX0}, {24'd0, h0});
    end else begin
      chk({tag, "_b_hex2"}, {24'd0, bus_b.HEX2}, {24'd0, h2});
      chk({tag, "_b_hex1"}, {24'd0, bus_b.HEX1}, {24'd0, h1});
      chk({tag, "_b_hex0"}, {24'd0, bus_b.HEX0}, {24'd0, h0});
    end
  endtask

  initial begin
    int lat, bc, dcnt;
    n_total = 0; n_pass = 0; n_fail = 0;
    cmp_en  = 1'b0;
    rst     = 1'b1;
    load_r  = 1'b0;
    value_r = 8'd0;

    repeat (2) @(negedge clk);
    chk_hex("reset", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    chk("reset_busy", {31'd0, bus_b.busy}, 32'd0);
    chk("reset_done", {31'd0, bus_b.done}, 32'd0);
    cmp_en = 1'b1;
    rst    = 1'b0;
    repeat (20) @(negedge clk);
    chk_hex("idle", 8'hFF, 8'hFF, 8'hFF, 1'b0);

    do_load(8'd255, lat, bc);
    chk("lat_255", lat, 32'd9);
    chk("busy_cycles_255", bc, 32'd9);
    chk_hex("v255", 8'hA4, 8'h92, 8'h92, 1'b0);

    do_load(8'd0, lat, bc);
    chk_hex("v0", 8'hFF, 8'hFF, 8'hC0, 1'b0);
    chk_hex("v0", 8'hC0, 8'hC0, 8'hC0, 1'b1);

    do_load(8'd7, lat, bc);
    chk_hex("v7", 8'hFF, 8'hFF, 8'hF8, 1'b0);
    chk_hex("v7", 8'hC0, 8'hC0, 8'hF8, 1'b1);

    do_load(8'd100, lat, bc);
    chk_hex("v100", 8'hF9, 8'hC0, 8'hC0, 1'b0);

    do_load(8'd9, lat, bc);
    chk_hex("v9", 8'hFF, 8'hFF, 8'h90, 1'b0);

    // load during busy: second strobe must be dropped
    value_r = 8'd42;
    load_r  = 1'b1;
    @(negedge clk);
    load_r = 1'b0;
    repeat (2) @(negedge clk);
    value_r = 8'd200;
    load_r  = 1'b1;
    dcnt    = 0;
    @(negedge clk);
    load_r = 1'b0;
    repeat (25) begin
      dcnt += int'(bus_b.done);
      @(negedge clk);
    end
    chk("busy_load_dones", dcnt, 32'd1);
    chk_hex("v42", 8'hFF, 8'h99, 8'hA4, 1'b0);

    // reset mid-conversion
    value_r = 8'd123;
    load_r  = 1'b1;
    @(negedge clk);
    load_r = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_hex("abort", 8'hFF, 8'hFF, 8'hFF, 1'b0);
    chk("abort_busy", {31'd0, bus_b.busy}, 32'd0);
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      dcnt += int'(bus_b.done);
    end
    chk("abort_no_done", dcnt, 32'd0);
    do_load(8'd123, lat, bc);
    chk("lat_123", lat, 32'd9);
    chk_hex("v123", 8'hF9, 8'hA4, 8'hB0, 1'b0);

    // randomized traffic, checked by the per-cycle compare
    repeat (2000) begin
      value_r = 8'($urandom);
      load_r  = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    rst    = 1'b1;
    load_r = 1'b0;
    @(negedge clk);

    // load held high: one conversion every 10 clocks
    rst     = 1'b0;
    load_r  = 1'b1;
    value_r = 8'd58;
    dcnt    = 0;
    repeat (50) begin
      @(negedge clk);
      dcnt += int'(bus_b.done);
    end
    load_r = 1'b0;
    chk("throughput_dones", dcnt, 32'd5);
    chk_hex("v58", 8'hFF, 8'h92, 8'h80, 1'b0);
    repeat (12) @(negedge clk);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
